// File: rtl/pipe_arb.sv
// Round-robin arbiter feeding a 4-phase micropipeline input stage.
// Acknowledge is synchronized; each handshake phase is guarded by a timeout.
module pipe_arb #(
  parameter int N_REQ = 3,
  parameter int W     = 3,
  parameter int TMO   = 255,
  localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   src_valid,
  input  logic [N_REQ*W-1:0] src_data,
  output logic [N_REQ-1:0]   src_done,
  output logic               pipe_req,
  output logic [W-1:0]       pipe_data,
  input  logic               pipe_ack,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE, REQ_HI, REQ_LO, DONE, ERR
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          ack_s;
  logic [15:0]   cnt;
  logic          tmo_hit;
  logic [GW-1:0] last;
  logic [GW-1:0] win;
  logic          hit;
  logic [GW:0]   sum;
  logic [W-1:0]  words [N_REQ];

  assign ack_s   = sync[1];
  assign tmo_hit = (cnt == 16'(TMO - 1));

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = src_data[i*W +: W];
    end
  end

  // search from last+1 upward, wrapping; sum < 2*N_REQ so one fold suffices
  always_comb begin
    win = '0;
    hit = 1'b0;
    sum = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) begin
        sum = sum - (GW+1)'(N_REQ);
      end
      if (!hit && src_valid[sum[GW-1:0]]) begin
        hit = 1'b1;
        win = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (hit) state_nx = REQ_HI;
      REQ_HI: begin
        if (ack_s)        state_nx = REQ_LO;
        else if (tmo_hit) state_nx = ERR;
      end
      REQ_LO: begin
        if (!ack_s)       state_nx = DONE;
        else if (tmo_hit) state_nx = ERR;
      end
      DONE:   state_nx = IDLE;
      ERR:    state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= '0;
      cnt       <= '0;
      last      <= GW'(N_REQ - 1);
      grant_id  <= '0;
      pipe_data <= '0;
    end else begin
      state <= state_nx;
      sync  <= {sync[0], pipe_ack};
      if (state_nx != state) cnt <= '0;
      else                   cnt <= cnt + 16'd1;
      if (state == IDLE && hit) begin
        grant_id  <= win;
        pipe_data <= words[win];
      end
      if (state == DONE) last <= grant_id;
    end
  end

  assign pipe_req = (state == REQ_HI);
  assign busy     = (state != IDLE);
  assign err      = (state == ERR);

  always_comb begin
    src_done = '0;
    if (state == DONE) src_done[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_pipe_arb.sv
// Bench for pipe_arb: directed scenarios plus a randomized run against
// a round-robin reference model and a delayed-echo acknowledge model.
module tb_pipe_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src_valid;
  logic [8:0] src_data;
  logic [2:0] src_done;
  logic       pipe_req;
  logic [2:0] pipe_data;
  logic       pipe_ack;
  logic       busy;
  logic [1:0] grant_id;
  logic       err;

  logic [2:0] t_valid;
  logic [8:0] t_data;
  logic [2:0] t_done;
  logic       t_req;
  logic [2:0] t_pdata;
  logic       t_ack;
  logic       t_busy;
  logic [1:0] t_gid;
  logic       t_err;

  int checks = 0;
  int errors = 0;
  bit ack_rand = 1'b0;

  pipe_arb #(.N_REQ(3), .W(3), .TMO(255)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data),
    .src_done(src_done), .pipe_req(pipe_req),
    .pipe_data(pipe_data), .pipe_ack(pipe_ack),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  pipe_arb #(.N_REQ(3), .W(3), .TMO(8)) dut_tmo (
    .clk(clk), .rst(rst),
    .src_valid(t_valid), .src_data(t_data),
    .src_done(t_done), .pipe_req(t_req),
    .pipe_data(t_pdata), .pipe_ack(t_ack),
    .busy(t_busy), .grant_id(t_gid), .err(t_err)
  );

  always #5 clk = ~clk;

  // first stage model: ack follows req after a (possibly random) delay
  initial begin
    int cnt_a;
    int dly;
    cnt_a = 0;
    dly = 0;
    pipe_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (pipe_req !== pipe_ack) begin
        if (cnt_a >= dly) begin
          pipe_ack = pipe_req;
          cnt_a = 0;
          dly = ack_rand ? int'($urandom_range(0, 20)) : 0;
        end else begin
          cnt_a++;
        end
      end
    end
  end

  function automatic int rr(input int lst, input logic [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      if (v[(lst + k) % 3]) return (lst + k) % 3;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    t_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = '0;
    src_data = '0;
    t_valid = '0;
    t_data = '0;
    t_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (pipe_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b want 0", pipe_req);
    end
    if (pipe_data !== 3'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", pipe_data);
    end
    if (src_done !== 3'd0) begin
      errors++; $display("FAIL reset_done: got %b want 000", src_done);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err);
    end
    if (grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_gid: got %0d want 0", grant_id);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n_done;
    bit saw_lo;
    logic [2:0] dv;
    do_reset();
    src_data = 9'b000_101_000;
    src_valid = 3'b010;
    for (int i = 0; i < 20 && pipe_req !== 1'b1; i++) @(negedge clk);
    checks += 3;
    if (pipe_req !== 1'b1) begin
      errors++; $display("FAIL single_req: got %b want 1", pipe_req);
    end
    if (pipe_data !== 3'b101) begin
      errors++; $display("FAIL single_data: got %b want 101", pipe_data);
    end
    if (grant_id !== 2'd1) begin
      errors++; $display("FAIL single_gid: got %0d want 1", grant_id);
    end
    src_valid = '0;
    n_done = 0;
    saw_lo = 1'b0;
    dv = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (src_done != 3'd0) begin
        n_done++;
        dv = src_done;
      end else if (busy && !pipe_req) begin
        saw_lo = 1'b1;
      end
    end
    checks += 4;
    if (n_done != 1) begin
      errors++; $display("FAIL single_count: got %0d want 1", n_done);
    end
    if (dv !== 3'b010) begin
      errors++; $display("FAIL single_done: got %b want 010", dv);
    end
    if (!saw_lo) begin
      errors++; $display("FAIL single_lo: got 0 want 1");
    end
    if (grant_id !== 2'd1) begin
      errors++; $display("FAIL single_hold_gid: got %0d want 1", grant_id);
    end
  endtask

  task automatic test_fairness();
    int nd;
    int m_last;
    int exp_id;
    int cnt [3];
    do_reset();
    src_valid = 3'b111;
    src_data = 9'($urandom);
    nd = 0;
    m_last = 2;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 1000 && nd < 6; i++) begin
      @(negedge clk);
      if (src_done != 3'd0) begin
        exp_id = (m_last + 1) % 3;
        checks += 2;
        if (src_done !== 3'(1 << exp_id)) begin
          errors++;
          $display("FAIL fair_order: got %b want %b", src_done, 3'(1 << exp_id));
        end
        if (grant_id !== 2'(exp_id)) begin
          errors++; $display("FAIL fair_gid: got %0d want %0d", grant_id, exp_id);
        end
        for (int b = 0; b < 3; b++) if (src_done[b]) cnt[b]++;
        m_last = exp_id;
        nd++;
        if (nd == 6) src_valid = '0;
      end
    end
    checks++;
    if (nd != 6) begin
      errors++; $display("FAIL fair_total: got %0d want 6", nd);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (cnt[b] != 2) begin
        errors++; $display("FAIL fair_bit%0d: got %0d want 2", b, cnt[b]);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0] d;
    int n_done;
    do_reset();
    d = 3'($urandom);
    src_data = {d, 6'($urandom)};
    src_valid = 3'b100;
    for (int i = 0; i < 20 && pipe_req !== 1'b1; i++) @(negedge clk);
    checks++;
    if (pipe_req !== 1'b1 || pipe_data !== d) begin
      errors++; $display("FAIL hold_start: got req=%b data=%b want 1/%b", pipe_req, pipe_data, d);
    end
    src_data = ~src_data;
    src_valid = '0;
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (src_done != 3'd0) begin
        n_done++;
        checks++;
        if (src_done !== 3'b100) begin
          errors++; $display("FAIL hold_done: got %b want 100", src_done);
        end
      end else if (busy) begin
        checks++;
        if (pipe_data !== d) begin
          errors++; $display("FAIL hold_data: got %b want %b", pipe_data, d);
        end
      end
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL hold_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    t_ack = 1'b0;
    t_valid = 3'b001;
    for (int i = 0; i < 10 && t_req !== 1'b1; i++) @(negedge clk);
    checks++;
    if (t_req !== 1'b1) begin
      errors++; $display("FAIL tmo_entry: got %b want 1", t_req);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (t_err !== 1'b0 || t_req !== 1'b1) begin
      errors++; $display("FAIL tmo_early: got err=%b req=%b want 0/1", t_err, t_req);
    end
    @(negedge clk);
    checks++;
    if (t_err !== 1'b1 || t_req !== 1'b0 || t_busy !== 1'b1) begin
      errors++; $display("FAIL tmo_hit: got err=%b req=%b busy=%b want 1/0/1", t_err, t_req, t_busy);
    end
    t_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      t_ack = i[2];
      checks++;
      if (t_err !== 1'b1 || t_req !== 1'b0 || t_done !== 3'd0) begin
        errors++; $display("FAIL tmo_sticky: got err=%b req=%b done=%b want 1/0/000", t_err, t_req, t_done);
      end
    end
    t_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (t_err !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: got %b want 0", t_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    src_valid = 3'b100;
    for (int i = 0; i < 60 && !(busy && !pipe_req && src_done == 3'd0 && pipe_data !== 3'bx && i > 2); i++)
      @(negedge clk);
    checks++;
    if (!(busy === 1'b1 && pipe_req === 1'b0 && src_done === 3'd0)) begin
      errors++; $display("FAIL rmid_reach: got busy=%b req=%b want 1/0", busy, pipe_req);
    end
    rst = 1'b1;
    src_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (pipe_req !== 1'b0 || busy !== 1'b0 || src_done !== 3'd0) begin
      errors++; $display("FAIL rmid_drop: got req=%b busy=%b done=%b want 0/0/000", pipe_req, busy, src_done);
    end
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (src_done != 3'd0) begin
        got = 1'b1;
        src_valid = '0;
        checks += 2;
        if (src_done !== 3'b001) begin
          errors++; $display("FAIL rmid_first: got %b want 001", src_done);
        end
        if (grant_id !== 2'd0) begin
          errors++; $display("FAIL rmid_gid: got %0d want 0", grant_id);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rmid_timeout: got none want 001");
    end
    src_valid = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_random();
    int ntx;
    int m_last;
    int exp_id;
    logic [2:0] exp_data;
    bit pending;
    do_reset();
    ack_rand = 1'b1;
    ntx = 0;
    m_last = 2;
    exp_id = 0;
    exp_data = '0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 90000 && ntx < 1000; cyc++) begin
      @(negedge clk);
      if (src_done != 3'd0) begin
        checks++;
        if (!pending || src_done !== 3'(1 << exp_id) || err !== 1'b0) begin
          errors++;
          $display("FAIL rnd_done: got %b err=%b want %b err=0", src_done, err, 3'(1 << exp_id));
        end
        pending = 1'b0;
        m_last = exp_id;
        ntx++;
      end else if (busy) begin
        checks++;
        if (pipe_data !== exp_data || grant_id !== 2'(exp_id)) begin
          errors++;
          $display("FAIL rnd_hold: got data=%b gid=%0d want %b/%0d", pipe_data, grant_id, exp_data, exp_id);
        end
      end
      src_valid = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
      src_data = 9'($urandom);
      if (!busy && src_valid != 3'd0) begin
        exp_id = rr(m_last, src_valid);
        exp_data = src_data[exp_id*3 +: 3];
        pending = 1'b1;
      end
    end
    checks += 2;
    if (ntx != 1000) begin
      errors++; $display("FAIL rnd_count: got %0d want 1000", ntx);
    end
    if (err !== 1'b0) begin
      errors++; $display("FAIL rnd_err: got %b want 0", err);
    end
    src_valid = '0;
    ack_rand = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_arb.md
PIPE_ARB -- requirements
Module: pipe_arb

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (2..8).
REQ-002 Parameter W, default 3: payload width, matches the micropipeline data width.
REQ-003 Parameter TMO, default 255: handshake-phase timeout in clock cycles (1..65535).
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port src_valid, input, N_REQ: bit i high means requester i has a word to send.
REQ-007 Port src_data, input, N_REQ*W: word of requester i occupies bits [i*W +: W].
REQ-008 Port src_done, output, N_REQ: one-cycle pulse on bit i when requester i's word completes the full 4-phase handshake.
REQ-009 Port pipe_req, output, 1: 4-phase request into the first micropipeline stage (req_in).
REQ-010 Port pipe_data, output, W: payload into the first stage (data_in).
REQ-011 Port pipe_ack, input, 1: asynchronous acknowledge from the first stage (ack_out).
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port grant_id, output, clog2(N_REQ) bits: index of the requester currently being served; holds its last value when idle.
REQ-014 Port err, output, 1: sticky timeout flag.

Function
REQ-015 pipe_ack shall pass through a 2-flop synchronizer (ack_s) before any use; no other logic samples the raw pipe_ack.
REQ-016 FSM states: IDLE, REQ_HI, REQ_LO, DONE, ERR.
REQ-017 IDLE: if any src_valid bit is high, select a winner round-robin, register grant_id and the winner's src_data into pipe_data in the same cycle, and go to REQ_HI; otherwise remain in IDLE.
REQ-018 Round-robin: the search starts at (last served index + 1) mod N_REQ; after reset the last served index is N_REQ-1, so index 0 has first priority.
REQ-019 REQ_HI: pipe_req=1; on ack_s==1, go to REQ_LO.
REQ-020 REQ_LO: pipe_req=0; on ack_s==0, go to DONE.
REQ-021 DONE: pulse src_done[grant_id] for exactly one cycle, update the last served index to grant_id, and go to IDLE.
REQ-022 pipe_data shall stay constant from entry to REQ_HI until exit from REQ_LO; it changes only on a registered IDLE selection.
REQ-023 The captured payload is used once selected; deasserting src_valid or changing src_data mid-transaction does not abort or alter the transaction.
REQ-024 The minimum transaction cost is 1 cycle in IDLE, plus one cycle in each of REQ_HI, REQ_LO and DONE, plus the synchronizer latency of each ack edge.
REQ-025 With pipe_ack returned immediately, the next selection is made in the cycle after DONE.
REQ-026 A per-phase counter shall reset on every entry to REQ_HI or REQ_LO.
REQ-027 If the counter reaches TMO before the awaited ack_s level, go to ERR.
REQ-028 ERR: pipe_req=0, err=1, src_done=0; remain in ERR until rst.
REQ-029 A requester holding src_valid continuously shall be served at least once every N_REQ transactions; no starvation.
REQ-030 src_done shall never assert on more than one bit at a time.

Reset
REQ-031 While rst=1: state=IDLE, pipe_req=0, pipe_data=0, src_done=0, busy=0, err=0, grant_id=0, last served index=N_REQ-1, synchronizer flops=0, counter=0.
REQ-032 Reset asserted mid-transaction (REQ_HI or REQ_LO) shall drop pipe_req to 0 on the next edge and discard the transaction with no src_done pulse.

Verification
REQ-033 Single requester, with the ack model echoing req after 1 cycle: src_valid=3'b010, src_data[5:3]=3'b101 -> pipe_data=3'b101, pipe_req high then low, one src_done=3'b010 pulse, grant_id=1.
REQ-034 Fairness: all three src_valid held high for 6 transactions -> grant order 0,1,2,0,1,2, and each src_done bit pulses twice.
REQ-035 Hold check: src_data changed and src_valid dropped while in REQ_HI -> pipe_data unchanged, the transaction completes, and src_done pulses.
REQ-036 Timeout: TMO=8 with pipe_ack stuck at 0 -> ERR entered 8 cycles after REQ_HI entry, err=1, pipe_req=0, and both stay so until rst.
REQ-037 Reset in REQ_LO -> next cycle pipe_req=0, busy=0, no src_done; after release, index 0 wins first.
REQ-038 Random ack delays of 0-20 cycles over 1000 transactions -> pipe_data stable while pipe_req=1 or while in REQ_LO, exactly one src_done per transaction, and no err.
